// File: rtl/alien_formation_ctrl.sv
// Alien formation marcher: steps the formation origin every P frames,
// reversing/descending at the live-column edges and flagging a landing.
module alien_formation_ctrl #(
   parameter int ALIASIZE     = 16,
   parameter int COLS         = 8,
   parameter int ROWS         = 5,
   parameter int COL_PITCH    = 24,
   parameter int ROW_PITCH    = 20,
   parameter int START_X      = 40,
   parameter int START_Y      = 48,
   parameter int STEP_X       = 4,
   parameter int STEP_Y       = 8,
   parameter int LEFT_BOUND   = 8,
   parameter int RIGHT_BOUND  = 632,
   parameter int BOTTOM_LIMIT = 400,
   parameter int MIN_PERIOD   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            frame_tick,
   input  logic [COLS-1:0] alive_cols,
   output logic [9:0]      formation_x,
   output logic [9:0]      formation_y,
   output logic            move_right,
   output logic            anim_frame,
   output logic            step_pulse,
   output logic            landed,
   output logic            busy
);
   localparam int CW = $clog2(2*COLS+1);
   localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {
      S_IDLE, S_MARCH, S_DESCEND, S_LANDED
   } state_t;

   state_t          r_state, w_state;
   logic [9:0]      r_x, w_x, r_y, w_y;
   logic            r_right, w_right;
   logic            r_anim, w_anim;
   logic            r_pulse, w_pulse;
   logic            r_landed, w_landed;
   logic [CW-1:0]   r_cnt, w_cnt;

   logic [CW-1:0]   w_pop, w_period;
   logic [IW-1:0]   w_first, w_last;
   logic [10:0]     w_left, w_rgt, w_ny;
   logic            w_live;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_x      <= 10'(START_X);
         r_y      <= 10'(START_Y);
         r_right  <= 1'b1;
         r_anim   <= 1'b0;
         r_pulse  <= 1'b0;
         r_landed <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state;
         r_x      <= w_x;
         r_y      <= w_y;
         r_right  <= w_right;
         r_anim   <= w_anim;
         r_pulse  <= w_pulse;
         r_landed <= w_landed;
         r_cnt    <= w_cnt;
      end
   end

   // Live extent and speed both follow the surviving columns.
   always_comb begin
      w_pop   = '0;
      w_first = '0;
      w_last  = '0;
      for (int c = 0; c < COLS; c++)
         w_pop = w_pop + CW'(alive_cols[c]);
      for (int c = COLS-1; c >= 0; c--)
         if (alive_cols[c]) w_first = IW'(c);
      for (int c = 0; c < COLS; c++)
         if (alive_cols[c]) w_last = IW'(c);
      w_live   = |alive_cols;
      w_period = ({w_pop, 1'b0} < (CW+1)'(MIN_PERIOD)) ?
                 CW'(MIN_PERIOD) : CW'({w_pop, 1'b0});
      w_left   = 11'(r_x) + 11'(w_first) * 11'(COL_PITCH);
      w_rgt    = 11'(r_x) + 11'(w_last) * 11'(COL_PITCH)
               + 11'(ALIASIZE);
      w_ny     = 11'(r_y) + 11'(STEP_Y);
   end

   always_comb begin
      w_state  = r_state;
      w_x      = r_x;
      w_y      = r_y;
      w_right  = r_right;
      w_anim   = r_anim;
      w_pulse  = 1'b0;
      w_landed = r_landed;
      w_cnt    = r_cnt;
      if (start) begin
         w_state  = S_MARCH;
         w_x      = 10'(START_X);
         w_y      = 10'(START_Y);
         w_right  = 1'b1;
         w_anim   = 1'b0;
         w_landed = 1'b0;
         w_cnt    = '0;
      end else if ((r_state == S_MARCH || r_state == S_DESCEND)
                   && frame_tick && w_live) begin
         if (r_cnt >= w_period - CW'(1)) begin
            w_cnt   = '0;
            w_pulse = 1'b1;
            w_anim  = ~r_anim;
            if (r_state == S_MARCH) begin
               if (r_right && (w_rgt + 11'(STEP_X) > 11'(RIGHT_BOUND)))
                  w_state = S_DESCEND;
               else if (!r_right &&
                        (w_left < 11'(LEFT_BOUND + STEP_X)))
                  w_state = S_DESCEND;
               else if (r_right)
                  w_x = r_x + 10'(STEP_X);
               else
                  w_x = r_x - 10'(STEP_X);
            end else begin
               w_y     = w_ny[9:0];
               w_right = ~r_right;
               if (w_ny + 11'((ROWS-1)*ROW_PITCH + ALIASIZE)
                   >= 11'(BOTTOM_LIMIT)) begin
                  w_state  = S_LANDED;
                  w_landed = 1'b1;
               end else begin
                  w_state  = S_MARCH;
               end
            end
         end else begin
            w_cnt = r_cnt + CW'(1);
         end
      end
   end

   assign formation_x = r_x;
   assign formation_y = r_y;
   assign move_right  = r_right;
   assign anim_frame  = r_anim;
   assign step_pulse  = r_pulse;
   assign landed      = r_landed;
   assign busy        = (r_state == S_MARCH) || (r_state == S_DESCEND);
endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Directed bench for alien_formation_ctrl with hand-computed expectations.
module tb_alien_formation_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] alive_cols = 8'h00;
   logic [9:0] formation_x, formation_y;
   logic       move_right, anim_frame, step_pulse, landed, busy;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int descents;
   logic [9:0] last_y, hold_x, hold_y;

   alien_formation_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .frame_tick(frame_tick), .alive_cols(alive_cols),
      .formation_x(formation_x), .formation_y(formation_y),
      .move_right(move_right), .anim_frame(anim_frame),
      .step_pulse(step_pulse), .landed(landed), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (step_pulse) pulses++;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("rst_x", formation_x, 40);
      chk("rst_y", formation_y, 48);
      chk("rst_dir", move_right, 1);
      chk("rst_anim", anim_frame, 0);
      chk("rst_pulse", step_pulse, 0);
      chk("rst_landed", landed, 0);
      chk("rst_busy", busy, 0);
      tick();
      chk("idle_tick_x", formation_x, 40);

      // Full formation: P = 16
      alive_cols = 8'hFF;
      do_start();
      chk("start_busy", busy, 1);
      pulses = 0;
      ticks(15);
      chk("ff_15_pulses", pulses, 0);
      chk("ff_15_x", formation_x, 40);
      tick();
      chk("ff_16_x", formation_x, 44);
      chk("ff_16_pulse", step_pulse, 1);
      chk("ff_16_anim", anim_frame, 1);
      cyc();
      chk("ff_pulse_1cyc", step_pulse, 0);

      // Single column: P = 2, march to right edge
      alive_cols = 8'h01;
      do_start();
      chk("s1_anim0", anim_frame, 0);
      pulses = 0;
      ticks(288);
      chk("s1_x616", formation_x, 616);
      chk("s1_steps", pulses, 144);
      ticks(2);
      chk("s1_edge_x", formation_x, 616);
      chk("s1_edge_y", formation_y, 48);
      chk("s1_edge_busy", busy, 1);
      ticks(2);
      chk("s1_desc_y", formation_y, 56);
      chk("s1_desc_dir", move_right, 0);
      chk("s1_desc_x", formation_x, 616);

      // Repeated descents until landing
      do_start();
      descents = 0;
      last_y = formation_y;
      for (int i = 0; i < 20000 && !landed; i++) begin
         tick();
         if (formation_y != last_y) descents++;
         last_y = formation_y;
      end
      chk("land_flag", landed, 1);
      chk("land_y", formation_y, 304);
      chk("land_count", descents, 32);
      chk("land_busy", busy, 0);
      chk("land_x", formation_x, 8);
      chk("land_dir", move_right, 1);
      pulses = 0;
      ticks(10);
      chk("land_hold_pulses", pulses, 0);
      chk("land_hold_y", formation_y, 304);
      chk("land_hold_x", formation_x, 8);
      do_start();
      chk("restart_landed", landed, 0);
      chk("restart_x", formation_x, 40);
      chk("restart_y", formation_y, 48);
      chk("restart_busy", busy, 1);

      // Period change 8 -> 4 and narrowed right edge
      alive_cols = 8'h0F;
      do_start();
      pulses = 0;
      ticks(7);
      chk("p8_7_pulses", pulses, 0);
      tick();
      chk("p8_x", formation_x, 44);
      alive_cols = 8'h03;
      pulses = 0;
      ticks(3);
      chk("p4_3_pulses", pulses, 0);
      tick();
      chk("p4_x", formation_x, 48);
      ticks(544);
      chk("c1_x592", formation_x, 592);
      ticks(4);
      chk("c1_edge_x", formation_x, 592);
      chk("c1_edge_y", formation_y, 48);
      ticks(4);
      chk("c1_desc_y", formation_y, 56);
      chk("c1_desc_dir", move_right, 0);

      // No live columns: frozen
      alive_cols = 8'h00;
      hold_x = formation_x;
      hold_y = formation_y;
      pulses = 0;
      ticks(50);
      chk("dead_pulses", pulses, 0);
      chk("dead_x", formation_x, hold_x);
      chk("dead_y", formation_y, hold_y);

      // start together with frame_tick
      alive_cols = 8'h01;
      start = 1'b1;
      frame_tick = 1'b1;
      cyc();
      start = 1'b0;
      frame_tick = 1'b0;
      chk("st_tick_x", formation_x, 40);
      chk("st_tick_pulse", step_pulse, 0);
      tick();
      chk("st_tick_nostep", step_pulse, 0);
      tick();
      chk("st_tick_step", formation_x, 44);

      // Reset while descending
      ticks(288);
      chk("pre_rst_x", formation_x, 616);
      chk("pre_rst_busy", busy, 1);
      tick();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_rst_x", formation_x, 40);
      chk("mid_rst_y", formation_y, 48);
      chk("mid_rst_dir", move_right, 1);
      chk("mid_rst_anim", anim_frame, 0);
      chk("mid_rst_pulse", step_pulse, 0);
      chk("mid_rst_landed", landed, 0);
      chk("mid_rst_busy", busy, 0);
      ticks(4);
      chk("mid_rst_idle_y", formation_y, 48);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alien_formation_ctrl.md
# alien_formation_ctrl

Sequential controller that marches the alien formation across the playfield and produces the formation origin (`formation_x`, `formation_y`). Each alien sprite drawer takes its `alien_left_x`/`alien_top_y` from this origin plus its column/row pitch offset. Movement advances one step per N frame ticks. The formation reverses and descends when its live horizontal extent would cross a bound, and flags `landed` when the bottom row reaches the player zone. Outputs change only on the cycle after a `frame_tick`, so sprite coordinates are stable for the whole visible frame.

## Interface
- `ALIASIZE`, 16: sprite width/height in pixels.
- `COLS`, 8: formation columns.
- `ROWS`, 5: formation rows.
- `COL_PITCH`, 24: x distance between column origins.
- `ROW_PITCH`, 20: y distance between row origins.
- `START_X`, 40: origin x after reset or start.
- `START_Y`, 48: origin y after reset or start.
- `STEP_X`, 4: horizontal step in pixels.
- `STEP_Y`, 8: descent step in pixels.
- `LEFT_BOUND`, 8: leftmost legal pixel x.
- `RIGHT_BOUND`, 632: rightmost edge limit (exclusive).
- `BOTTOM_LIMIT`, 400: landing threshold y.
- `MIN_PERIOD`, 2: minimum frames per step.

Ports:
- `clk` in 1: system/pixel clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that (re)starts a wave.
- `frame_tick` in 1: one-cycle pulse, once per frame (vsync).
- `alive_cols` in COLS: bit c set means column c still has a live alien.
- `formation_x` out 10: origin x of column 0.
- `formation_y` out 10: origin y of row 0.
- `move_right` out 1: current horizontal direction.
- `anim_frame` out 1: sprite animation phase; toggles on every step.
- `step_pulse` out 1: one-cycle pulse on every step.
- `landed` out 1: sticky; formation reached `BOTTOM_LIMIT`.
- `busy` out 1: high in MARCH or DESCEND.

## Operation
- States: IDLE, MARCH, DESCEND, LANDED.
- Reset values: state IDLE, `formation_x`=START_X, `formation_y`=START_Y, `move_right`=1, `anim_frame`=0, `step_pulse`=0, `landed`=0, `busy`=0, frame counter 0.
- `start` in any state: load START_X/START_Y, `move_right`=1, `anim_frame`=0, `landed`=0, counter 0, go to MARCH.
- Period P = max(MIN_PERIOD, 2 × popcount(`alive_cols`)). The formation speeds up as columns die.
- In MARCH/DESCEND, each `frame_tick` increments the counter. When counter ≥ P−1 on a tick, a step event occurs and the counter clears.
- Live extent: first = lowest set bit of `alive_cols`, last = highest set bit.
  - L = x + first×COL_PITCH.
  - R = x + last×COL_PITCH + ALIASIZE.
  - Compute in 11 bits; no wrap.
- Step event in MARCH:
  - If moving right and R+STEP_X > RIGHT_BOUND: go to DESCEND, x unchanged.
  - Else if moving left and L < LEFT_BOUND+STEP_X: go to DESCEND, x unchanged.
  - Else x ±= STEP_X.
- Step event in DESCEND:
  - y += STEP_Y, `move_right` inverts, go to MARCH.
  - If new y + (ROWS−1)×ROW_PITCH + ALIASIZE ≥ BOTTOM_LIMIT: go to LANDED, `landed`=1.
- Every step event, including edge and descent steps, pulses `step_pulse` and toggles `anim_frame`.
- `alive_cols`=0: step events are suppressed and the counter holds. Position and state freeze until `start`.
- LANDED: outputs hold and ticks are ignored until `start` or `reset`.
- IDLE: ticks ignored; outputs hold reset/start values.

## Timing
- Registered outputs only. A step triggered by the `frame_tick` in cycle n updates x/y/dir/`anim_frame`/`landed` and asserts `step_pulse` in cycle n+1. `step_pulse` is high for exactly one cycle.
- `alive_cols` is sampled in the same cycle as the triggering `frame_tick`.
- `start` and `frame_tick` in the same cycle: `start` wins and no step occurs.
- `reset` has priority over everything. Asserting it mid-wave yields reset values on the next edge.
- Back-to-back `frame_tick` pulses (every cycle) are legal. Each one counts.

## Test plan
- Reset, then `start`, `alive_cols`=8'hFF (P=16): the 16th tick yields `formation_x`=44 one cycle later, a single `step_pulse`, and `anim_frame`=1. Ticks 1–15 cause no change.
- `alive_cols`=8'h01 (P=2): x climbs 40→616 in steps of 4. The next step leaves x=616 and enters DESCEND. The following step gives y=56, `move_right`=0, and x=616 still.
- `alive_cols`=8'h0F then 8'h03 mid-wave: the step interval changes from 8 ticks to 4 ticks (MIN_PERIOD=2 not reached). The right-edge turn uses column 1, not column 7.
- Repeated descents with `alive_cols`=8'h01: the 32nd descent (y=304) asserts `landed`=1 and `busy`=0. Further ticks leave x/y unchanged. `start` clears `landed` and restores 40/48.
- `alive_cols`=0 during MARCH: 50 ticks produce no `step_pulse` and no motion.
- `start`+`frame_tick` in the same cycle: counter is 0 and there is no step.
- `reset` mid-DESCEND: all outputs take their reset values on the next edge.
